halt_ctrl: RTL



---
 rtl/halt_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/halt_ctrl.sv
// -----------------------------------------------------------------------------
// halt_ctrl -- program-termination controller for the pipelined CPU.
//
// This block watches the writeback retirement stream and keeps a shadow copy
// of the return-value register. When a halt instruction retires, it freezes
// the front end. Once the memory system is idle and at least DRAIN_MIN drain
// cycles have passed, it raises a sticky isHalt. From that point ret_val and
// retired are stable.
//
// Optional feature: define HALT_WATCHDOG_EN to build a RUN-cycle watchdog.
// When the watchdog expires, the block forces a halt and sets the sticky
// timeout flag. When the macro is undefined, timeout is tied low and no cycle
// counter is built.
//
// Parameters:
//   RET_REG    : register whose last retired write becomes ret_val (1..7)
//   DRAIN_MIN  : minimum number of cycles spent draining (>= 1)
//   MAX_CYCLES : watchdog limit in RUN cycles (used only with the watchdog)
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous, active-high reset
//   wb_valid  : one instruction retires this cycle
//   wb_isHalt : the retiring instruction is a halt (qualified by wb_valid)
//   wb_we     : the retiring instruction writes a register
//   wb_tgt    : destination register index
//   wb_data   : writeback data
//   mem_idle  : no outstanding loads or stores
//   freeze    : front-end stall/flush request
//   isHalt    : program finished (sticky)
//   ret_val   : return value
//   timeout   : halt was forced by the watchdog
//   retired   : retired-instruction count (saturating)
// -----------------------------------------------------------------------------
module halt_ctrl #(
  parameter int unsigned RET_REG    = 3,
  parameter int unsigned DRAIN_MIN  = 4,
  parameter int unsigned MAX_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        wb_isHalt,
  input  logic        wb_we,
  input  logic [2:0]  wb_tgt,
  input  logic [15:0] wb_data,
  input  logic        mem_idle,
  output logic        freeze,
  output logic        isHalt,
  output logic [15:0] ret_val,
  output logic        timeout,
  output logic [31:0] retired
);

  // A 1-bit counter is kept even when DRAIN_MIN is 1, so the vector is never
  // zero-width.
  localparam int unsigned DcW = (DRAIN_MIN > 1) ? $clog2(DRAIN_MIN) : 1;
  localparam logic [DcW-1:0] DrainLast = DcW'(DRAIN_MIN - 1);
  localparam logic [2:0] RetTgt = 3'(RET_REG);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  state_e state_q, state_d;

  logic           freeze_q, freeze_d;
  logic           is_halt_q, is_halt_d;
  logic [15:0]    ret_val_q, ret_val_d;
  logic [31:0]    retired_q, retired_d;
  logic [DcW-1:0] drain_cnt_q, drain_cnt_d;

  logic halt_retire;
  logic ret_write;
  logic wd_fire;

  assign halt_retire = wb_valid & wb_isHalt;
  // A halt never writes a register, so a write flagged on the halt beat is
  // dropped.
  assign ret_write   = wb_valid & wb_we & ~wb_isHalt & (wb_tgt == RetTgt);

`ifdef HALT_WATCHDOG_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        timeout_q, timeout_d;

  // A halt retiring on the expiry cycle takes precedence over the watchdog.
  assign wd_fire = (state_q == StRun) && (cycle_cnt_q == 32'(MAX_CYCLES - 1)) && !halt_retire;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    timeout_d   = timeout_q | wd_fire;
    if ((state_q == StRun) && !(&cycle_cnt_q)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_max_cycles;

  assign wd_fire           = 1'b0;
  assign timeout           = 1'b0;
  assign unused_max_cycles = ^MAX_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    freeze_d    = freeze_q;
    is_halt_d   = is_halt_q;
    ret_val_d   = ret_val_q;
    retired_d   = retired_q;
    drain_cnt_d = drain_cnt_q;

    unique case (state_q)
      StRun: begin
        if (wb_valid && !(&retired_q)) begin
          retired_d = retired_q + 32'd1;
        end
        if (ret_write) begin
          ret_val_d = wb_data;
        end
        if (halt_retire || wd_fire) begin
          state_d     = StDrain;
          freeze_d    = 1'b1;
          drain_cnt_d = '0;
        end
      end

      StDrain: begin
        // Writeback beats from younger instructions are ignored here.
        freeze_d = 1'b1;
        if (drain_cnt_q != DrainLast) begin
          drain_cnt_d = drain_cnt_q + DcW'(1);
        end else if (mem_idle) begin
          state_d   = StHalted;
          is_halt_d = 1'b1;
        end
      end

      StHalted: begin
        // All outputs are held until reset.
        freeze_d  = 1'b1;
        is_halt_d = 1'b1;
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      freeze_q    <= 1'b0;
      is_halt_q   <= 1'b0;
      ret_val_q   <= '0;
      retired_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      freeze_q    <= freeze_d;
      is_halt_q   <= is_halt_d;
      ret_val_q   <= ret_val_d;
      retired_q   <= retired_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign freeze  = freeze_q;
  assign isHalt  = is_halt_q;
  assign ret_val = ret_val_q;
  assign retired = retired_q;

endmodule
